// File: rtl/hdmi_pkg.sv
// Shared definitions for the TMDS timing controller: FSM encoding and
// default 640x480@60 timing.
package hdmi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Counter width able to hold 0..n-1, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tmds_sync_gen.sv
// Horizontal/vertical position counters and sync/active decode.
module tmds_sync_gen
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned HW       = 10,
  parameter int unsigned VW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          adv,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_last
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic h_last;
  logic v_last;
  logic hs_on;
  logic vs_on;

  // Comparisons are done at 32 bits so sync end points equal to the total never alias.
  assign h_last     = (32'(h_cnt) == H_TOTAL - 1);
  assign v_last     = (32'(v_cnt) == V_TOTAL - 1);
  assign frame_last = h_last && v_last;
  assign active     = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
  assign hs_on      = (32'(h_cnt) >= H_ACTIVE + H_FP) &&
                      (32'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
  assign vs_on      = (32'(v_cnt) >= V_ACTIVE + V_FP) &&
                      (32'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
  assign hsync      = hs_on ? SYNC_POL : ~SYNC_POL;
  assign vsync      = vs_on ? SYNC_POL : ~SYNC_POL;

  // Raster position: h advances every enabled clock, v on each h wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (adv) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tmds_timing_ctrl.sv
// Video timing controller feeding three TMDS encoders: run/stop sequencing,
// pixel handshake and registered encoder-side outputs.
//
// state | meaning
// IDLE  | counters parked at 0,0, outputs blanked, syncs deasserted
// RUN   | streaming frames continuously
// STOP  | finishing the current frame, then back to IDLE
module tmds_timing_ctrl
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_req,
  output logic        disp_en,
  output logic [1:0]  ctrl0,
  output logic [1:0]  ctrl1,
  output logic [1:0]  ctrl2,
  output logic [7:0]  data0,
  output logic [7:0]  data1,
  output logic [7:0]  data2,
  output logic        frame_start,
  output logic        underflow,
  output logic        busy
);

  localparam int unsigned HW = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned VW = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);

  state_t          state;
  state_t          state_nx;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            active;
  logic            hsync;
  logic            vsync;
  logic            frame_last;
  logic            run_st;
  logic            en_q;
  logic            en_rise_idle;

  assign run_st       = (state != ST_IDLE);
  assign pix_req      = run_st && active;
  assign busy         = run_st;
  assign en_rise_idle = (state == ST_IDLE) && en && !en_q;
  assign ctrl1        = 2'b00;
  assign ctrl2        = 2'b00;

  tmds_sync_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .HW(HW), .VW(VW)
  ) u_sync_gen (
    .clk        (clk),
    .reset      (reset),
    .clear      (!run_st),
    .adv        (run_st),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .active     (active),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_last (frame_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state; re-enabling during STOP resumes RUN without breaking the frame.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (en) state_nx = ST_RUN;
      ST_RUN:  if (!en) state_nx = ST_STOP;
      ST_STOP: begin
        if (en)              state_nx = ST_RUN;
        else if (frame_last) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Encoder-side outputs, one clock behind the raster position they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q        <= 1'b0;
      disp_en     <= 1'b0;
      data2       <= 8'h00;
      data1       <= 8'h00;
      data0       <= 8'h00;
      ctrl0       <= {~SYNC_POL, ~SYNC_POL};
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      en_q        <= en;
      disp_en     <= pix_req;
      data2       <= (pix_req && pix_valid) ? pix_data[23:16] : 8'h00;
      data1       <= (pix_req && pix_valid) ? pix_data[15:8]  : 8'h00;
      data0       <= (pix_req && pix_valid) ? pix_data[7:0]   : 8'h00;
      ctrl0       <= run_st ? {vsync, hsync} : {~SYNC_POL, ~SYNC_POL};
      frame_start <= run_st && (h_cnt == '0) && (v_cnt == '0);
      if (en_rise_idle)
        underflow <= 1'b0;
      else if (pix_req && !pix_valid)
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tmds_timing_ctrl.sv
// Directed bench for tmds_timing_ctrl with a tiny 8x5 raster
// (H 4/1/2/1, V 2/1/1/1, active-low syncs).
module tb_tmds_timing_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data = 24'h0;
  logic        pix_req;
  logic        disp_en;
  logic [1:0]  ctrl0;
  logic [1:0]  ctrl1;
  logic [1:0]  ctrl2;
  logic [7:0]  data0;
  logic [7:0]  data1;
  logic [7:0]  data2;
  logic        frame_start;
  logic        underflow;
  logic        busy;

  int total = 0;
  int bad   = 0;

  tmds_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_req(pix_req), .disp_en(disp_en),
    .ctrl0(ctrl0), .ctrl1(ctrl1), .ctrl2(ctrl2),
    .data0(data0), .data1(data1), .data2(data2),
    .frame_start(frame_start), .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic exp_req(input int h, input int v);
    return (h < 4) && (v < 2);
  endfunction

  function automatic logic [1:0] exp_ctrl0(input int h, input int v);
    return {(v == 3) ? 1'b0 : 1'b1, (h == 5 || h == 6) ? 1'b0 : 1'b1};
  endfunction

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; pix_valid = 1'b1; pix_data = 24'h010203;
    repeat (3) @(negedge clk);
    total++;
    if ({disp_en, data2, data1, data0} !== 25'h0) begin
      bad++; $display("FAIL reset_data got=%b/%h%h%h exp=0/000000", disp_en, data2, data1, data0);
    end
    total++;
    if ({ctrl0, ctrl1, ctrl2} !== 6'b110000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=110000", {ctrl0, ctrl1, ctrl2});
    end
    total++;
    if ({frame_start, underflow, busy, pix_req} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {frame_start, underflow, busy, pix_req});
    end
  endtask

  task automatic test_run();
    int h, v, req_cnt, fs_cnt, fs_first, fs_last, ph, pv;
    logic        preq;
    logic [23:0] pdata, exp_d;
    req_cnt = 0; fs_cnt = 0; fs_first = 0; fs_last = 0;
    ph = 0; pv = 0; preq = 1'b0; pdata = 24'h0;
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 80; k++) begin
      h = k % 8;
      v = (k / 8) % 5;
      if (k > 0) begin
        exp_d = preq ? pdata : 24'h0;
        total++;
        if (disp_en !== preq || {data2, data1, data0} !== exp_d) begin
          bad++; $display("FAIL run_data k=%0d got=%b/%h%h%h exp=%b/%h", k, disp_en, data2, data1, data0, preq, exp_d);
        end
        total++;
        if (ctrl0 !== exp_ctrl0(ph, pv)) begin
          bad++; $display("FAIL run_ctrl0 k=%0d got=%b exp=%b", k, ctrl0, exp_ctrl0(ph, pv));
        end
        total++;
        if (frame_start !== (ph == 0 && pv == 0)) begin
          bad++; $display("FAIL run_frame_start k=%0d got=%b", k, frame_start);
        end
        if (k == 1) begin
          total++;
          if ({data2, data1, data0} !== 24'h010203) begin
            bad++; $display("FAIL run_first_pixel got=%h%h%h exp=010203", data2, data1, data0);
          end
        end
        if (frame_start === 1'b1) begin
          if (fs_cnt == 0) fs_first = k;
          fs_last = k;
          fs_cnt++;
        end
        if (preq) pix_data = pix_data + 24'd1;
      end
      total++;
      if (pix_req !== exp_req(h, v) || busy !== 1'b1) begin
        bad++; $display("FAIL run_pix_req k=%0d got=%b busy=%b exp=%b", k, pix_req, busy, exp_req(h, v));
      end
      if (pix_req === 1'b1) req_cnt++;
      ph = h; pv = v; preq = exp_req(h, v); pdata = pix_data;
      @(negedge clk);
    end
    total++;
    if (req_cnt != 16) begin
      bad++; $display("FAIL run_req_count got=%0d exp=16", req_cnt);
    end
    total++;
    if (fs_cnt != 2 || fs_last - fs_first != 40) begin
      bad++; $display("FAIL run_frame_period got=%0d pulses spacing %0d exp=2 spacing 40", fs_cnt, fs_last - fs_first);
    end
    total++;
    if ({ctrl1, ctrl2} !== 4'b0000) begin
      bad++; $display("FAIL run_ctrl12 got=%b exp=0000", {ctrl1, ctrl2});
    end
  endtask

  // Entered at raster (0,0) of a running frame.
  task automatic test_underflow();
    logic [23:0] saved;
    int n;
    saved = pix_data;
    pix_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({disp_en, data2, data1, data0} !== 25'h1000000 || underflow !== 1'b1) begin
      bad++; $display("FAIL uf_hole got=%b/%h%h%h uf=%b exp=1/000000 uf=1", disp_en, data2, data1, data0, underflow);
    end
    pix_valid = 1'b1;
    @(negedge clk);
    total++;
    if ({data2, data1, data0} !== saved || underflow !== 1'b1) begin
      bad++; $display("FAIL uf_resume got=%h%h%h uf=%b exp=%h uf=1", data2, data1, data0, underflow, saved);
    end
    pix_data = pix_data + 24'd1;
    en = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0 || n != 38) begin
      bad++; $display("FAIL uf_stop_len got=%0d cycles busy=%b exp=38 busy=0", n, busy);
    end
    total++;
    if (frame_start !== 1'b0 || underflow !== 1'b1) begin
      bad++; $display("FAIL uf_idle_entry got fs=%b uf=%b exp fs=0 uf=1", frame_start, underflow);
    end
    @(negedge clk);
    total++;
    if ({frame_start, busy, pix_req, underflow} !== 4'b0001 || ctrl0 !== 2'b11) begin
      bad++; $display("FAIL uf_idle got=%b ctrl0=%b exp=0001 ctrl0=11", {frame_start, busy, pix_req, underflow}, ctrl0);
    end
    en = 1'b1;
    @(negedge clk);
    total++;
    if (underflow !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL uf_clear got uf=%b busy=%b exp uf=0 busy=1", underflow, busy);
    end
    @(negedge clk);
    total++;
    if (frame_start !== 1'b1) begin
      bad++; $display("FAIL uf_restart_fs got=%b exp=1", frame_start);
    end
  endtask

  // Entered at raster position 1 of a running frame.
  task automatic test_stop();
    int nbad;
    repeat (9) @(negedge clk);
    en = 1'b0;
    for (int s = 1; s <= 30; s++) begin
      @(negedge clk);
      if (s == 1) begin
        total++;
        if (pix_req !== 1'b1) begin
          bad++; $display("FAIL stop_pix_req got=%b exp=1", pix_req);
        end
      end
      if (s == 2) begin
        total++;
        if (disp_en !== 1'b1) begin
          bad++; $display("FAIL stop_disp_en got=%b exp=1", disp_en);
        end
      end
      if (s == 17) begin
        total++;
        if (ctrl0 !== 2'b01) begin
          bad++; $display("FAIL stop_vsync got=%b exp=01", ctrl0);
        end
      end
      if (s == 29) begin
        total++;
        if (busy !== 1'b1) begin
          bad++; $display("FAIL stop_last_busy got=%b exp=1", busy);
        end
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL stop_idle got busy=%b exp=0", busy);
    end
    en = 1'b1;
    @(negedge clk);
    repeat (20) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    nbad = 0;
    for (int p = 31; p <= 41; p++) begin
      @(negedge clk);
      if (busy !== 1'b1) nbad++;
      if (p == 40) begin
        total++;
        if (pix_req !== 1'b1) begin
          bad++; $display("FAIL resume_pix_req got=%b exp=1", pix_req);
        end
      end
    end
    total++;
    if (nbad != 0 || frame_start !== 1'b1) begin
      bad++; $display("FAIL resume_continuous got idle_cycles=%0d fs=%b exp=0 fs=1", nbad, frame_start);
    end
  endtask

  // Entered at raster position 1 of a running frame.
  task automatic test_async_reset();
    pix_valid = 1'b0;
    @(negedge clk);
    pix_valid = 1'b1;
    @(negedge clk);
    total++;
    if (disp_en !== 1'b1 || underflow !== 1'b1) begin
      bad++; $display("FAIL areset_pre got de=%b uf=%b exp de=1 uf=1", disp_en, underflow);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if ({disp_en, data2, data1, data0} !== 25'h0 || ctrl0 !== 2'b11) begin
      bad++; $display("FAIL areset_data got=%b/%h%h%h ctrl0=%b exp=0/000000 ctrl0=11", disp_en, data2, data1, data0, ctrl0);
    end
    total++;
    if ({frame_start, underflow, busy, pix_req} !== 4'b0000) begin
      bad++; $display("FAIL areset_flags got=%b exp=0000", {frame_start, underflow, busy, pix_req});
    end
    #1 reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || pix_req !== 1'b1) begin
      bad++; $display("FAIL areset_restart got busy=%b req=%b exp 1 1", busy, pix_req);
    end
    @(negedge clk);
    total++;
    if (frame_start !== 1'b1 || disp_en !== 1'b1) begin
      bad++; $display("FAIL areset_first_frame got fs=%b de=%b exp 1 1", frame_start, disp_en);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_underflow();
    test_stop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmds_timing_ctrl.md
TMDS_TIMING_CTRL -- requirements
Module: tmds_timing_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch, clocks
- H_SYNC, 96, hsync width, clocks
- H_BP, 48, horizontal back porch, clocks
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vsync width, lines
- V_BP, 33, vertical back porch, lines
- SYNC_POL, 0, sync level when asserted (0 = active-low)

REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1, pixel clock
- reset, in, 1, asynchronous active-low reset
- en, in, 1, stream enable
- pix_valid, in, 1, source has pixel on pix_data
- pix_data, in, 24, {R,G,B} pixel
- pix_req, out, 1, controller consumes pixel this cycle
- disp_en, out, 1, to all three encoders
- ctrl0, out, 2, {vsync,hsync} to blue-channel encoder
- ctrl1, out, 2, to green-channel encoder, constant 00
- ctrl2, out, 2, to red-channel encoder, constant 00
- data0, out, 8, blue byte
- data1, out, 8, green byte
- data2, out, 8, red byte
- frame_start, out, 1, one-cycle pulse at h=0, v=0
- underflow, out, 1, sticky underflow flag
- busy, out, 1, high in RUN or STOP

Function
REQ-003 SHALL count h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1, where H_TOTAL and V_TOTAL are the sums of the four respective parameters.
REQ-004 h_cnt SHALL wrap to 0 after H_TOTAL-1; v_cnt SHALL increment only on h_cnt wrap and SHALL wrap to 0 after V_TOTAL-1.
REQ-005 Active region SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-006 hsync SHALL be asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-007 vsync SHALL be asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for the whole line.
REQ-008 Asserted sync level SHALL be SYNC_POL; deasserted level SHALL be ~SYNC_POL.
REQ-009 pix_req SHALL be combinational: high exactly when the state is RUN or STOP and the counters are in the active region.
REQ-010 A pixel SHALL be consumed when pix_req=1, regardless of pix_valid; the source must advance only on pix_req & pix_valid.
REQ-011 All outputs except pix_req SHALL be registered, one clock latency from the counter value to disp_en/ctrl/data.
REQ-012 In the active region, disp_en SHALL be 1 and data2/1/0 SHALL be pix_data[23:16]/[15:8]/[7:0]; if pix_valid=0, data SHALL be 0x00 and underflow SHALL set.
REQ-013 In blanking, disp_en SHALL be 0 and data SHALL be 0x00.
REQ-014 underflow SHALL clear only on reset or on the en 0->1 transition in IDLE.
REQ-015 FSM SHALL have the states IDLE, RUN and STOP:
- IDLE: counters held at 0, outputs at blanking with syncs deasserted; en=1 -> RUN on the next clock
- RUN: en=0 -> STOP
- STOP: completes the current frame; on the v_cnt/h_cnt wrap to 0,0 -> IDLE; en=1 during STOP -> RUN, with no frame break
REQ-016 frame_start SHALL pulse on the first cycle of every frame in RUN, including the first frame after IDLE; it SHALL NOT pulse on the STOP->IDLE wrap.

Reset
REQ-017 While reset=0: state=IDLE, counters=0, disp_en=0, data=0x00, ctrl0={~SYNC_POL,~SYNC_POL}, frame_start=0, underflow=0, busy=0.
REQ-018 Reset assertion mid-frame SHALL take effect immediately (asynchronous); after release the block SHALL restart in IDLE.

Structure
REQ-019 A shared package hdmi_pkg SHALL hold the FSM state encoding and the default 640x480@60 timing constants.
REQ-020 Counters and sync decode SHALL live in one sub-module, tmds_sync_gen; the FSM, handshake and output registers SHALL live in the top module.

Verification (bench parameters H=4/1/2/1, V=2/1/1/1, SYNC_POL=0; H_TOTAL=8, V_TOTAL=5)
REQ-021 Reset held, en=1 -> all outputs at REQ-017 values, pix_req=0.
REQ-022 en=1 with pix_valid=1, pix_data incrementing from 0x010203 -> disp_en high for 4 clocks on lines 0-1 only; first output data2/1/0=01/02/03 one clock after the first pix_req; frame_start every 40 clocks.
REQ-023 Same run -> ctrl0[0]=0 for h=5..6 (one clock later at the output); ctrl0[1]=0 for all of line 3; 8 pix_req per frame.
REQ-024 Drop pix_valid for one active cycle -> that pixel output is 00/00/00, underflow=1 stays set; toggling en low in IDLE then high clears it.
REQ-025 Drop en at h=2, v=1 -> frame completes through v=4, h=7, then IDLE with busy=0; raising en during STOP -> continuous next frame with frame_start.
REQ-026 Assert reset at h=3, v=0 -> outputs reach reset values without waiting for a clock edge.
